// File: rtl/uart_line_mon.sv
// uart_line_mon: UART receive monitor for the rt_top bench.
// It oversamples the DUT transmit pin, rebuilds 8N1 characters and groups
// them into text lines that the VIP pulls with a valid/ready handshake.
// Optional feature macro: UART_MON_PARITY_EN selects 8E1 frames with an
// even-parity check; when it is undefined, frames are 8N1 and no parity
// logic exists.

module uart_line_mon #(
    parameter int BaudDiv = 868,
    parameter int LineLen = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rx_i,
    output logic [7:0]                   char_o,
    output logic                         char_valid_o,
    output logic [8*LineLen-1:0]         line_data_o,
    output logic [$clog2(LineLen+1)-1:0] line_len_o,
    output logic                         line_valid_o,
    input  logic                         line_ready_i,
    output logic                         frame_err_o,
    output logic                         overflow_o
);

    localparam int BAUD_W = $clog2(BaudDiv);
    localparam int LEN_W  = $clog2(LineLen+1);

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_MON_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t state, state_next;

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic              fall_edge;
    logic [BAUD_W-1:0] baud_cnt;
    logic              baud_tick;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic              parity_bad;

    // FSM control strobes
    logic load_half;
    logic load_full;
    logic shift_en;
    logic stop_sample;

    // Line assembly helpers
    logic             handshake;
    logic [LEN_W-1:0] wr_idx;

    assign fall_edge = rx_prev & ~rx_sync;
    assign baud_tick = (baud_cnt == '0);
    assign handshake = line_valid_o & line_ready_i;
    // After a handshake the incoming char starts a fresh line at byte 0
    assign wr_idx    = handshake ? '0 : line_len_o;

    // Two-flop synchroniser plus edge-detect flop; all idle high after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, exactly like the hardware does.
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            S_IDLE:  if (fall_edge) state_next = S_START;
            S_START: if (baud_tick) state_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA: begin
                if (baud_tick && bit_cnt == 3'd7) begin
`ifdef UART_MON_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_MON_PARITY_EN
            S_PARITY: if (baud_tick) state_next = S_STOP;
`endif
            S_STOP:  if (baud_tick) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM output strobes for the bit-timing datapath
    always_comb begin
        load_half   = (state == S_IDLE) && fall_edge;
        load_full   = (state != S_IDLE) && baud_tick;
        shift_en    = (state == S_DATA) && baud_tick;
        stop_sample = (state == S_STOP) && baud_tick;
    end

    // Baud counter: half a bit to reach mid start-bit, then whole bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)             baud_cnt <= '0;
        else if (load_half)    baud_cnt <= BAUD_W'(BaudDiv/2);
        else if (load_full)    baud_cnt <= BAUD_W'(BaudDiv-1);
        else if (!baud_tick)   baud_cnt <= baud_cnt - 1'b1;
    end

    // Bit counter and LSB-first data shift register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (load_half) begin
            bit_cnt   <= '0;
        end else if (shift_en) begin
            bit_cnt   <= bit_cnt + 1'b1;
            shift_reg <= {rx_sync, shift_reg[7:1]};
        end
    end

`ifdef UART_MON_PARITY_EN
    logic parity_sample;
    assign parity_sample = (state == S_PARITY) && baud_tick;

    // Even parity: data bits plus parity bit must XOR to zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              parity_bad <= 1'b0;
        else if (parity_sample) parity_bad <= (^shift_reg) ^ rx_sync;
    end
`else
    assign parity_bad = 1'b0;
`endif

    // Character delivery: pulse char_valid_o or frame_err_o after the stop bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            char_o       <= '0;
            char_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            char_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            if (stop_sample) begin
                if (rx_sync && !parity_bad) begin
                    char_o       <= shift_reg;
                    char_valid_o <= 1'b1;
                end else begin
                    frame_err_o  <= 1'b1;
                end
            end
        end
    end

    // Line assembly, emit and handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: the line buffer is reset because it drives line_data_o
        // directly and unused bytes must read as zero.
        if (rst_i) begin
            line_data_o  <= '0;
            line_len_o   <= '0;
            line_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            if (handshake) begin
                line_data_o  <= '0;
                line_len_o   <= '0;
                line_valid_o <= 1'b0;
            end
            if (char_valid_o) begin
                if (line_valid_o && !handshake) begin
                    overflow_o <= 1'b1;
                end else if (char_o == CHAR_CR) begin
                    // carriage returns never reach the line
                end else if (char_o == CHAR_LF) begin
                    line_valid_o <= 1'b1;
                end else begin
                    line_data_o[8*wr_idx +: 8] <= char_o;
                    line_len_o                 <= wr_idx + 1'b1;
                    if (wr_idx + 1'b1 == LEN_W'(LineLen))
                        line_valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_line_mon.sv
// tb_uart_line_mon: directed self-checking bench for uart_line_mon with
// BaudDiv=16 and LineLen=4.

module tb_uart_line_mon;

    localparam int BaudDiv = 16;
    localparam int LineLen = 4;
    localparam int LEN_W   = $clog2(LineLen+1);

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 rx_i;
    logic [7:0]           char_o;
    logic                 char_valid_o;
    logic [8*LineLen-1:0] line_data_o;
    logic [LEN_W-1:0]     line_len_o;
    logic                 line_valid_o;
    logic                 line_ready_i;
    logic                 frame_err_o;
    logic                 overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state
    int             cyc = 0;
    int             char_cnt = 0;
    int             ferr_cnt = 0;
    int             line_cnt = 0;
    int             pulse_cyc = 0;
    logic [7:0]     last_char = '0;
    logic [31:0]    cap_data = '0;
    int             cap_len = 0;

    uart_line_mon #(.BaudDiv(BaudDiv), .LineLen(LineLen)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .char_o       (char_o),
        .char_valid_o (char_valid_o),
        .line_data_o  (line_data_o),
        .line_len_o   (line_len_o),
        .line_valid_o (line_valid_o),
        .line_ready_i (line_ready_i),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Observe pulses and accepted lines mid-cycle
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (char_valid_o) begin
                char_cnt  = char_cnt + 1;
                last_char = char_o;
                pulse_cyc = cyc;
            end
            if (frame_err_o) ferr_cnt = ferr_cnt + 1;
            if (line_valid_o && line_ready_i) begin
                line_cnt = line_cnt + 1;
                cap_data = line_data_o;
                cap_len  = int'(line_len_o);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        idle(BaudDiv);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            idle(BaudDiv);
        end
`ifdef UART_MON_PARITY_EN
        rx_i = ^b;
        idle(BaudDiv);
`endif
        rx_i = stop_bit;
        idle(BaudDiv);
        rx_i = 1'b1;
        idle(4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_char"},       char_o,       8'h00);
        check({tag, "_char_valid"}, char_valid_o, 1'b0);
        check({tag, "_line_data"},  line_data_o,  32'h0);
        check({tag, "_line_len"},   line_len_o,   '0);
        check({tag, "_line_valid"}, line_valid_o, 1'b0);
        check({tag, "_frame_err"},  frame_err_o,  1'b0);
        check({tag, "_overflow"},   overflow_o,   1'b0);
    endtask

    initial begin
        int start_cyc;
        int lat;
        int c0, f0, l0;

        rst_i        = 1'b1;
        rx_i         = 1'b1;
        line_ready_i = 1'b0;

        // Reset held with the line toggling
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            rx_i = ~rx_i;
        end
        check_all_zero("rst");
        rx_i  = 1'b1;
        rst_i = 1'b0;
        idle(20);
        check_all_zero("post_rst");

        // Single character latency and value
        line_ready_i = 1'b1;
        start_cyc = cyc;
        send_byte(8'h41, 1'b1);
        lat = pulse_cyc - start_cyc;
        $display("char latency %0d cycles", lat);
        check("lat_window", (lat >= 154 && lat <= 157), 1'b1);
        check("a_count", char_cnt, 1);
        check("a_value", last_char, 8'h41);
        check("a_len", line_len_o, 1);
        send_byte(8'h0A, 1'b1);
        check("a_line_cnt", line_cnt, 1);
        check("a_line_len", cap_len, 1);
        check("a_line_data", cap_data, 32'h0000_0041);

        // "hi\r\n" with ready held high
        send_byte(8'h68, 1'b1);
        send_byte(8'h69, 1'b1);
        send_byte(8'h0D, 1'b1);
        check("hi_no_line_yet", line_cnt, 1);
        send_byte(8'h0A, 1'b1);
        check("hi_line_cnt", line_cnt, 2);
        check("hi_len", cap_len, 2);
        check("hi_data", cap_data, 32'h0000_6968);
        check("hi_valid_dropped", line_valid_o, 1'b0);
        check("hi_buf_empty", line_len_o, 0);

        // Bad stop bit with one char already buffered
        send_byte(8'h78, 1'b1);
        c0 = char_cnt;
        send_byte(8'h55, 1'b0);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_char", char_cnt, c0);
        check("ferr_len_kept", line_len_o, 1);

        // Short low glitch must not start a frame
        c0 = char_cnt;
        f0 = ferr_cnt;
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(3 * BaudDiv);
        check("glitch_no_char", char_cnt, c0);
        check("glitch_no_ferr", ferr_cnt, f0);
        check("glitch_len_kept", line_len_o, 1);
        send_byte(8'h0A, 1'b1);
        check("x_line_data", cap_data, 32'h0000_0078);

        // Full line with ready low, then overflow on later chars
        line_ready_i = 1'b0;
        c0 = char_cnt;
        l0 = line_cnt;
        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b1);
        send_byte(8'h63, 1'b1);
        send_byte(8'h64, 1'b1);
        check("full_valid", line_valid_o, 1'b1);
        check("full_no_ovf_yet", overflow_o, 1'b0);
        send_byte(8'h65, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h0A, 1'b1);
        check("ovf_char_pulses", char_cnt - c0, 7);
        check("ovf_sticky", overflow_o, 1'b1);
        check("held_len", line_len_o, 4);
        check("held_data", line_data_o, 32'h6463_6261);
        line_ready_i = 1'b1;
        idle(2);
        check("drain_valid", line_valid_o, 1'b0);
        check("drain_len", line_len_o, 0);
        check("drain_data", line_data_o, 32'h0);
        check("drain_cap_len", cap_len, 4);
        check("drain_line_cnt", line_cnt, l0 + 1);
        check("ovf_still_set", overflow_o, 1'b1);

        // Bare line feed emits an empty line
        send_byte(8'h0A, 1'b1);
        check("empty_line_cnt", line_cnt, l0 + 2);
        check("empty_line_len", cap_len, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
